// File: rtl/intersection_controller.sv
// Two-road traffic light controller. North-south holds green by default; east-west and
// pedestrian requests are latched and served once the minimum north-south dwell has elapsed.
module intersection_controller #(
    parameter int unsigned T_NS_GREEN_MIN = 8,
    parameter int unsigned T_EW_GREEN     = 6,
    parameter int unsigned T_YELLOW       = 2,
    parameter int unsigned T_ALL_RED      = 1,
    parameter int unsigned T_RED_YELLOW   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       ped_walk,
    output logic [2:0] state,
    output logic [3:0] counter,
    output logic       pending
);

    if (T_NS_GREEN_MIN < 1 || T_NS_GREEN_MIN > 15 || T_EW_GREEN < 1 || T_EW_GREEN > 15 ||
        T_YELLOW < 1 || T_YELLOW > 15 || T_ALL_RED < 1 || T_ALL_RED > 15 ||
        T_RED_YELLOW < 1 || T_RED_YELLOW > 15) begin : gen_bad_timing
        $error("intersection_controller: every T_* parameter must lie in 1..15");
    end

    typedef enum logic [2:0] {
        StNsGreen     = 3'd0,
        StNsYellow    = 3'd1,
        StAllRedA     = 3'd2,
        StEwRedYellow = 3'd3,
        StEwGreen     = 3'd4,
        StEwYellow    = 3'd5,
        StAllRedB     = 3'd6,
        StNsRedYellow = 3'd7
    } state_e;

    localparam logic [3:0] NsGreenLast   = 4'(T_NS_GREEN_MIN - 1);
    localparam logic [3:0] EwGreenLast   = 4'(T_EW_GREEN - 1);
    localparam logic [3:0] YellowLast    = 4'(T_YELLOW - 1);
    localparam logic [3:0] AllRedLast    = 4'(T_ALL_RED - 1);
    localparam logic [3:0] RedYellowLast = 4'(T_RED_YELLOW - 1);

    state_e     state_q, state_d;
    logic [3:0] counter_q, counter_d;
    logic       pending_q, pending_d;
    logic [3:0] dwell_last;
    logic       leave;

    always_comb begin
        dwell_last = NsGreenLast;
        case (state_q)
            StNsGreen:                   dwell_last = NsGreenLast;
            StNsYellow, StEwYellow:      dwell_last = YellowLast;
            StAllRedA, StAllRedB:        dwell_last = AllRedLast;
            StEwRedYellow, StNsRedYellow: dwell_last = RedYellowLast;
            StEwGreen:                   dwell_last = EwGreenLast;
            default:                     dwell_last = NsGreenLast;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        pending_d = pending_q;
        // NS green only yields once its minimum has run out and someone is waiting.
        leave = (counter_q == dwell_last) && ((state_q != StNsGreen) || pending_q);
        if ((ew_req || ped_req) && (state_q != StEwGreen)) begin
            pending_d = 1'b1;
        end
        if (leave) begin
            state_d   = state_e'(state_q + 3'd1);
            counter_d = 4'd0;
            if (state_d == StEwGreen) begin
                pending_d = 1'b0;
            end
        end else if (!((state_q == StNsGreen) && (counter_q == NsGreenLast))) begin
            counter_d = counter_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StNsGreen;
            counter_q <= 4'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            pending_q <= pending_d;
        end
    end

    assign state   = state_q;
    assign counter = counter_q;
    assign pending = pending_q;

    assign ns_green  = (state_q == StNsGreen);
    assign ns_yellow = (state_q == StNsYellow) || (state_q == StNsRedYellow);
    assign ns_red    = (state_q != StNsGreen) && (state_q != StNsYellow);
    assign ew_green  = (state_q == StEwGreen);
    assign ew_yellow = (state_q == StEwRedYellow) || (state_q == StEwYellow);
    assign ew_red    = (state_q != StEwGreen) && (state_q != StEwYellow);
    assign ped_walk  = (state_q == StEwGreen);

endmodule

// File: tb/tb_intersection_controller.sv
// Scoreboarded bench for intersection_controller: a cycle model predicts every output,
// scenario checks cover dwell lengths, request latching and mid-dwell reset.
module tb_intersection_controller;

    localparam int TNs = 8;
    localparam int TEw = 6;
    localparam int TY  = 2;
    localparam int TAR = 1;
    localparam int TRY = 1;

    logic       clk = 1'b0;
    logic       rst, ew_req, ped_req;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk;
    logic [2:0] state;
    logic [3:0] counter;
    logic       pending;

    intersection_controller #(
        .T_NS_GREEN_MIN(TNs),
        .T_EW_GREEN    (TEw),
        .T_YELLOW      (TY),
        .T_ALL_RED     (TAR),
        .T_RED_YELLOW  (TRY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ew_req   (ew_req),
        .ped_req  (ped_req),
        .ns_red   (ns_red),
        .ns_yellow(ns_yellow),
        .ns_green (ns_green),
        .ew_red   (ew_red),
        .ew_yellow(ew_yellow),
        .ew_green (ew_green),
        .ped_walk (ped_walk),
        .state    (state),
        .counter  (counter),
        .pending  (pending)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] cnt;
        logic       pend;
        logic [6:0] lamps;
    } exp_t;

    typedef struct packed {
        logic [2:0] st;
        logic       pend;
        logic       walk;
    } obs_t;

    exp_t sb_q[$];
    obs_t trace_q[$];
    int   run_st[$];
    int   run_len[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_state = 0;
    int   m_cnt = 0;
    bit   m_pend = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dwell(input int s);
        case (s)
            0:       return TNs;
            1, 5:    return TY;
            2, 6:    return TAR;
            3, 7:    return TRY;
            default: return TEw;
        endcase
    endfunction

    // Lamp order: ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk.
    function automatic logic [6:0] lamp_model(input int s);
        return {s >= 2, s == 1 || s == 7, s == 0, !(s == 4 || s == 5), s == 3 || s == 5,
                s == 4, s == 4};
    endfunction

    task automatic model_step(input logic r, input logic req);
        bit done;
        bit new_pend;
        if (r) begin
            m_state = 0;
            m_cnt   = 0;
            m_pend  = 1'b0;
            return;
        end
        done     = (m_cnt == dwell(m_state) - 1) && (m_state != 0 || m_pend);
        new_pend = m_pend || (req && m_state != 4);
        if (done) begin
            m_state = (m_state + 1) % 8;
            m_cnt   = 0;
            if (m_state == 4) new_pend = 1'b0;
        end else if (m_state != 0 || m_cnt < TNs - 1) begin
            m_cnt++;
        end
        m_pend = new_pend;
    endtask

    task automatic cycle(input logic r, input logic ew, input logic ped);
        exp_t e;
        rst     = r;
        ew_req  = ew;
        ped_req = ped;
        model_step(r, ew | ped);
        e.st    = 3'(m_state);
        e.cnt   = 4'(m_cnt);
        e.pend  = m_pend;
        e.lamps = lamp_model(m_state);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("state", 32'(state), 32'(e.st));
        check_eq("counter", 32'(counter), 32'(e.cnt));
        check_eq("pending", 32'(pending), 32'(e.pend));
        check_eq("lamps", 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
                               ped_walk}), 32'(e.lamps));
        check_eq("safety", 32'((ns_green & ew_green) | (ns_green & ew_yellow) |
                               (ew_green & ns_yellow)), 32'd0);
        trace_q.push_back({state, pending, ped_walk});
    endtask

    task automatic run_until(input int tgt, input logic ew, input logic ped, input int budget,
                             input string tag);
        for (int i = 0; i < budget && m_state != tgt; i++) cycle(1'b0, ew, ped);
        check_eq(tag, 32'(state), 32'(tgt));
    endtask

    task automatic compute_runs();
        run_st.delete();
        run_len.delete();
        foreach (trace_q[i]) begin
            if (i == 0 || trace_q[i].st != trace_q[i-1].st) begin
                run_st.push_back(int'(trace_q[i].st));
                run_len.push_back(1);
            end else begin
                run_len[run_len.size()-1]++;
            end
        end
    endtask

    function automatic int rl(input int i);
        return (i < run_len.size()) ? run_len[i] : -1;
    endfunction

    function automatic int rs(input int i);
        return (i < run_st.size()) ? run_st[i] : -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int exp_dw[8];
        int cnt;
        int idx;
        exp_dw = '{TNs, TY, TAR, TRY, TEw, TY, TAR, TRY};
        rst = 1'b1;
        ew_req = 1'b0;
        ped_req = 1'b0;

        // Idle: NS green forever, counter saturated.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (50) cycle(1'b0, 1'b0, 1'b0);
        check_eq("idle_state", 32'(state), 32'd0);
        check_eq("idle_counter", 32'(counter), 32'(TNs - 1));

        // Early request: full phase dwell table.
        trace_q.delete();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (24) cycle(1'b0, 1'b0, 1'b0);
        compute_runs();
        for (int i = 0; i < 8; i++) begin
            check_eq("early_dwell", 32'(rl(i)), 32'(exp_dw[i]));
            check_eq("early_run_state", 32'(rs(i)), 32'(i));
        end
        check_eq("early_return_ns", 32'(trace_q[22].st), 32'd0);
        for (int i = TNs + TY + TAR + TRY; i < trace_q.size(); i++)
            check_eq("early_pend_clear", 32'(trace_q[i].pend), 32'd0);

        // Late request on saturated NS green: one extra cycle of latency.
        trace_q.delete();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check_eq("late_pending", 32'(pending), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("late_ns_yellow", 32'(state), 32'd1);
        repeat (30) cycle(1'b0, 1'b0, 1'b0);
        cnt = 0;
        foreach (trace_q[i]) if (trace_q[i].walk) cnt++;
        check_eq("late_walk_cycles", 32'(cnt), 32'(TEw));

        // Requests during EW green are ignored.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        run_until(4, 1'b0, 1'b0, 40, "ign_reach_ewg");
        run_until(5, 1'b1, 1'b0, 20, "ign_reach_ewy");
        run_until(0, 1'b0, 1'b0, 20, "ign_back_ns");
        check_eq("ign_pending", 32'(pending), 32'd0);
        trace_q.delete();
        repeat (30) cycle(1'b0, 1'b0, 1'b0);
        cnt = 0;
        foreach (trace_q[i]) if (trace_q[i].st != 3'd0) cnt++;
        check_eq("ign_no_second_phase", 32'(cnt), 32'd0);

        // Request held across the clear: re-latched in EW yellow, second phase after 8 cycles.
        trace_q.delete();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (55) cycle(1'b0, 1'b1, 1'b0);
        compute_runs();
        idx = 1;
        while (idx < trace_q.size() && trace_q[idx].st != 3'd6) idx++;
        check_eq("held_pend_in_ewy", 32'(trace_q[idx-1].pend), 32'd1);
        check_eq("held_ns_dwell", 32'(rl(8)), 32'(TNs));
        check_eq("held_next_state", 32'(rs(9)), 32'd1);
        check_eq("held_second_ew", 32'(rs(12)), 32'd4);

        // Reset in the middle of EW green.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        run_until(4, 1'b0, 1'b0, 40, "mid_reach_ewg");
        for (int i = 0; i < 10 && m_cnt != 3; i++) cycle(1'b0, 1'b0, 1'b0);
        check_eq("mid_pre_counter", 32'(counter), 32'd3);
        cycle(1'b1, 1'b0, 1'b0);
        check_eq("mid_state", 32'(state), 32'd0);
        check_eq("mid_counter", 32'(counter), 32'd0);
        check_eq("mid_pending", 32'(pending), 32'd0);
        check_eq("mid_ns_green", 32'(ns_green), 32'd1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
